core_ctrl: RTL

Multi-cycle sequencer for the RV32I core. Owns the PC, the instruction register, and the retired-instruction counter. Drives the instruction-fetch and data-memory handshakes and walks each instruction through fetch, decode, execute, memory and writeback. Consumes the class strobes of the combinational instruction decoder and raises traps on illegal instructions, `ecall` and (optionally) misalignment.

---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/misalign_chk.sv | 47 ++++
 rtl/core_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the RV32I multi-cycle core: sequencer state
//   encoding, trap cause codes, the data-memory size encoding, reset
//   defaults used by both the sequencer and the datapath, and the alignment
//   helper used by the optional misalignment checker.
//
//   Optional feature macro (consumed by core_ctrl): RV32I_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
package rv32i_pkg;

    // Sequencer states. The encoding is visible on core_ctrl.dbg_state.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Trap cause codes (mcause exception numbers).
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    // mem_size encoding driven by the datapath.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Reset defaults shared with the datapath.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
    localparam logic [31:0] IR_RESET         = 32'h0000_0000;

    // True when an access of the given size at the given low address bits
    // does not sit on its natural boundary. The reserved size 2'b11 is
    // treated like a word so it can never slip through as "aligned".
    function automatic logic addr_misaligned(input logic [1:0] addr_lo,
                                             input logic [1:0] size);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            default:   bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/misalign_chk.sv
// -----------------------------------------------------------------------------
// misalign_chk
//   Combinational alignment check evaluated while the sequencer is in EXEC.
//   Only instantiated when RV32I_MISALIGN_TRAP_EN is defined.
//
//   Ports
//     is_load, is_store      in  : memory-class strobes from the decoder
//     is_branch, is_jal,
//     is_jalr                in  : control-transfer strobes from the decoder
//     branch_taken           in  : ALU compare result
//     addr_lo                in  : mem_addr[1:0]
//     mem_size               in  : access size (byte/half/word)
//     target_lo              in  : jump_target[1:0]
//     load_misalign          out : load to a misaligned address
//     store_misalign         out : store to a misaligned address
//     jump_misalign          out : taken transfer to a non-word-aligned target
// -----------------------------------------------------------------------------
module misalign_chk
    import rv32i_pkg::*;
(
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_branch,
    input  logic       is_jal,
    input  logic       is_jalr,
    input  logic       branch_taken,
    input  logic [1:0] addr_lo,
    input  logic [1:0] mem_size,
    input  logic [1:0] target_lo,
    output logic       load_misalign,
    output logic       store_misalign,
    output logic       jump_misalign
);

    logic access_bad;
    logic transfer;

    assign access_bad     = addr_misaligned(addr_lo, mem_size);
    assign load_misalign  = is_load  && access_bad;
    assign store_misalign = is_store && access_bad;

    // Only a transfer that actually redirects the PC can fault; a not-taken
    // branch falls through to pc+4, which is always aligned.
    assign transfer      = is_jal || is_jalr || (is_branch && branch_taken);
    assign jump_misalign = transfer && (target_lo != 2'b00);

endmodule

// File: rtl/core_ctrl.sv
// -----------------------------------------------------------------------------
// core_ctrl
//   Multi-cycle sequencer for the RV32I core. Owns pc, the instruction
//   register and the retired-instruction counter, drives the fetch and
//   data-memory handshakes and walks each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB. Illegal instructions and ecall
//   go through a one-cycle TRAP state that saves pc to mepc and redirects to
//   TRAP_VEC; ebreak parks the core in HALT until reset.
//
//   Handshakes: a request (imem_req / dmem_req) is a level held high, with
//   its address/write-enable stable, in every cycle of its own state; the
//   matching ack completes the transfer on the rising edge where both are
//   high. An ack seen in any other state is ignored, and a reset drops an
//   outstanding request without waiting for its ack.
//
//   Optional feature: `define RV32I_MISALIGN_TRAP_EN adds alignment checks
//   in EXEC (load -> cause 4, store -> cause 6, taken transfer -> cause 0).
//   Without it, WB forces the low two bits of jump targets to zero and
//   misaligned data addresses go to memory unchanged.
//
//   Ports
//     clk, rst                       : clock, synchronous active-high reset
//     imem_req/imem_addr             : fetch request, address = pc
//     imem_ack/imem_rdata            : fetch completion and instruction word
//     ir                             : instruction register (to decoder)
//     dec_err, is_*, wr_valid        : decoder strobes for ir
//     branch_taken, jump_target      : datapath results, valid in EXEC/WB
//     mem_addr, mem_size             : effective address and access size
//     dmem_req/dmem_we/dmem_ack      : data-memory handshake
//     rf_we                          : register-file write strobe (WB only)
//     pc, mepc, instret              : architectural state
//     trap, trap_cause, halted       : trap pulse, last cause, halt status
//     dbg_state                      : current sequencer state
// -----------------------------------------------------------------------------
module core_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    output logic [31:0] ir,

    input  logic        dec_err,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_ecall,
    input  logic        is_ebreak,
    input  logic        wr_valid,

    input  logic        branch_taken,
    input  logic [31:0] jump_target,

    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,

    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,

    output logic        rf_we,

    output logic [31:0] pc,
    output logic [31:0] mepc,
    output logic [31:0] instret,

    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic        halted,

    output logic [2:0]  dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, mepc_q, instret_q;
    logic [3:0]  cause_q, cause_d;
    logic        take_jump;

    // Redirect condition evaluated in WB; decoder strobes and datapath
    // results stay valid there because ir does not change until next fetch.
    assign take_jump = is_jal || is_jalr || (is_branch && branch_taken);

`ifdef RV32I_MISALIGN_TRAP_EN
    logic load_misalign, store_misalign, jump_misalign;
    logic unused_mem_hi;

    misalign_chk u_misalign_chk (
        .is_load        (is_load),
        .is_store       (is_store),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .branch_taken   (branch_taken),
        .addr_lo        (mem_addr[1:0]),
        .mem_size       (mem_size),
        .target_lo      (jump_target[1:0]),
        .load_misalign  (load_misalign),
        .store_misalign (store_misalign),
        .jump_misalign  (jump_misalign)
    );

    // Upper address bits matter to memory, not to the sequencer.
    assign unused_mem_hi = ^mem_addr[31:2];
`else
    // Without the checker the sequencer never looks at the data address and
    // the low target bits are discarded in WB.
    logic unused_inputs;
    assign unused_inputs = ^{mem_addr, mem_size, jump_target[1:0]};
`endif

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        trap     = 1'b0;
        halted   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (dec_err) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (is_ecall) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ECALL_M;
                end else if (is_ebreak) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
`ifdef RV32I_MISALIGN_TRAP_EN
                if (load_misalign) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_LOAD_MISALIGN;
                end else if (store_misalign) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_STORE_MISALIGN;
                end else if (jump_misalign) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_INSTR_MISALIGN;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
`else
                if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
`endif
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                rf_we   = wr_valid;
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                trap    = 1'b1;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and architectural registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= IR_RESET;
            mepc_q    <= 32'h0000_0000;
            instret_q <= 32'h0000_0000;
            cause_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;

            if (state_q == ST_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
            end

            if (state_q == ST_WB) begin
                instret_q <= instret_q + 32'd1;
                // With the checker enabled a misaligned target has already
                // trapped, so masking the low bits is harmless in both builds.
                if (take_jump) begin
                    pc_q <= {jump_target[31:2], 2'b00};
                end else begin
                    pc_q <= pc_q + 32'd4;
                end
            end

            if (state_q == ST_TRAP) begin
                mepc_q <= pc_q;
                pc_q   <= TRAP_VEC;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign mepc       = mepc_q;
    assign instret    = instret_q;
    assign trap_cause = cause_q;
    assign dbg_state  = state_q;

endmodule
